// File: rtl/multi_droop_mgr.sv
// Voltage-droop brake manager: merges per-source brake requests into a DCO code kick and a
// divider offset, then holds and ramps the divider offset back down before returning to OFF.
module multi_droop_mgr #(
    parameter int NSRC         = 4,
    parameter int NLVL         = 2,
    parameter int DW           = 32,
    parameter int CODE_BASE    = 1000000,
    parameter int DIV_BASE     = 10,
    parameter int DIV_STEP     = 1,
    parameter int HOLD_CYCLES  = 32,
    parameter int BRAKE_CYCLES = 500,
    localparam int LW = (NLVL > 1) ? $clog2(NLVL) : 1
) (
    input  logic                 refclk,
    input  logic                 resetn,
    input  logic [NSRC-1:0]      brake,
    input  logic [NSRC*LW-1:0]   brake_lvl,
    input  logic [NSRC-1:0]      src_mask,
    input  logic                 clr_count,
    output logic [1:0]           brake_state,
    output logic [LW-1:0]        active_lvl,
    output logic [DW-1:0]        delta_f,
    output logic [DW-1:0]        delta_n,
    output logic [15:0]          event_count
);

    localparam int CW = (BRAKE_CYCLES > 0) ? $clog2(BRAKE_CYCLES + 1) : 1;
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [DW-1:0] CODE_B  = DW'(CODE_BASE);
    localparam logic [DW-1:0] DIV_B   = DW'(DIV_BASE);
    localparam logic [DW-1:0] DIV_S   = DW'(DIV_STEP);
    localparam logic [LW:0]   NLVL_W  = (LW + 1)'(NLVL);
    localparam logic [LW-1:0] MAX_LVL = LW'(NLVL - 1);
    localparam logic [LW:0]   ONE     = (LW + 1)'(1);

    typedef enum logic [1:0] {
        OFF        = 2'd0,
        BRAKING    = 2'd1,
        RECOVERING = 2'd2,
        ILLEGAL    = 2'd3
    } state_t;

    state_t          state_q;
    logic [LW-1:0]   activeLvl_q;
    logic [DW-1:0]   divDelta_q;
    logic [CW-1:0]   countdown_q;
    logic [HW-1:0]   hold_q;
    logic [15:0]     eventCount_q;
    logic [15:0]     eventCount_d;

    logic            req;
    logic            esc;
    logic            eventInc;
    logic [LW-1:0]   reqLvl;
    logic [LW-1:0]   srcLvl;
    logic [LW-1:0]   newLvl;
    logic [LW:0]     reqMult;
    logic [LW:0]     newMult;
    logic [LW:0]     escMult;

    // Products are formed wide enough to never wrap, then clipped to the all-ones DW value.
    function automatic logic [DW-1:0] satMul(input logic [DW-1:0] base, input logic [LW:0] k);
        logic [DW+LW:0] prod;
        prod = {{(LW + 1){1'b0}}, base} * {{DW{1'b0}}, k};
        return (prod[DW+LW:DW] != '0) ? '1 : prod[DW-1:0];
    endfunction

    always_comb begin
        req    = 1'b0;
        reqLvl = '0;
        srcLvl = '0;
        for (int i = 0; i < NSRC; i++) begin
            srcLvl = brake_lvl[i*LW +: LW];
            if ({1'b0, srcLvl} >= NLVL_W) srcLvl = MAX_LVL;
            if (brake[i] && src_mask[i]) begin
                req = 1'b1;
                if (srcLvl > reqLvl) reqLvl = srcLvl;
            end
        end
    end

    always_comb begin
        esc      = req && (reqLvl > activeLvl_q) &&
                   (state_q == BRAKING || state_q == RECOVERING);
        newLvl   = esc ? reqLvl : activeLvl_q;
        reqMult  = {1'b0, reqLvl} + ONE;
        newMult  = {1'b0, newLvl} + ONE;
        escMult  = {1'b0, reqLvl} - {1'b0, activeLvl_q};
        eventInc = req && (state_q == OFF || state_q == RECOVERING);
        if (clr_count)
            eventCount_d = '0;
        else if (eventInc && eventCount_q != 16'hFFFF)
            eventCount_d = eventCount_q + 16'd1;
        else
            eventCount_d = eventCount_q;
    end

    // The first kick is combinational so the DCO reacts in the same cycle the droop is flagged.
    always_comb begin
        delta_f = '0;
        delta_n = '0;
        if (resetn) begin
            case (state_q)
                OFF: begin
                    if (req) begin
                        delta_f = satMul(CODE_B, reqMult);
                        delta_n = satMul(DIV_B, reqMult);
                    end
                end
                BRAKING, RECOVERING: begin
                    delta_n = divDelta_q;
                    if (esc) delta_f = satMul(CODE_B, escMult);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= OFF;
            activeLvl_q  <= '0;
            divDelta_q   <= '0;
            countdown_q  <= '0;
            hold_q       <= '0;
            eventCount_q <= '0;
        end else begin
            eventCount_q <= eventCount_d;
            case (state_q)
                OFF: begin
                    if (req) begin
                        state_q     <= BRAKING;
                        activeLvl_q <= reqLvl;
                        divDelta_q  <= satMul(DIV_B, reqMult);
                        countdown_q <= CW'(BRAKE_CYCLES);
                    end
                end
                BRAKING: begin
                    if (esc) begin
                        activeLvl_q <= reqLvl;
                        divDelta_q  <= satMul(DIV_B, reqMult);
                    end
                    if (req) begin
                        countdown_q <= CW'(BRAKE_CYCLES);
                    end else if (countdown_q != '0) begin
                        countdown_q <= countdown_q - 1'b1;
                    end else begin
                        state_q <= RECOVERING;
                        hold_q  <= HW'(HOLD_CYCLES);
                    end
                end
                RECOVERING: begin
                    if (req) begin
                        state_q     <= BRAKING;
                        countdown_q <= CW'(BRAKE_CYCLES);
                        activeLvl_q <= newLvl;
                        divDelta_q  <= satMul(DIV_B, newMult);
                    end else if (hold_q != '0) begin
                        hold_q <= hold_q - 1'b1;
                    end else if (divDelta_q >= DIV_S) begin
                        hold_q     <= HW'(HOLD_CYCLES);
                        divDelta_q <= divDelta_q - DIV_S;
                    end else begin
                        state_q     <= OFF;
                        activeLvl_q <= '0;
                        divDelta_q  <= '0;
                    end
                end
                default: begin
                    state_q     <= OFF;
                    activeLvl_q <= '0;
                    divDelta_q  <= '0;
                end
            endcase
        end
    end

    assign brake_state = state_q;
    assign active_lvl  = activeLvl_q;
    assign event_count = eventCount_q;

endmodule

// File: tb/tb_multi_droop_mgr.sv
// Directed bench for multi_droop_mgr: a default-parameter instance for timing and escalation,
// plus a short-timer NLVL=3 instance for level clamping and event counter saturation/clear.
module tb_multi_droop_mgr;

    logic        refclk;
    logic        resetn;
    logic [3:0]  brake;
    logic [3:0]  brakeLvl;
    logic [3:0]  srcMask;
    logic        clrCount;
    logic [1:0]  brakeState;
    logic [0:0]  activeLvl;
    logic [31:0] deltaF;
    logic [31:0] deltaN;
    logic [15:0] eventCount;

    logic [3:0]  brake2;
    logic [7:0]  brakeLvl2;
    logic [3:0]  srcMask2;
    logic        clrCount2;
    logic [1:0]  brakeState2;
    logic [1:0]  activeLvl2;
    logic [31:0] deltaF2;
    logic [31:0] deltaN2;
    logic [15:0] eventCount2;

    int errors = 0;
    int checks = 0;

    multi_droop_mgr dut (
        .refclk      (refclk),
        .resetn      (resetn),
        .brake       (brake),
        .brake_lvl   (brakeLvl),
        .src_mask    (srcMask),
        .clr_count   (clrCount),
        .brake_state (brakeState),
        .active_lvl  (activeLvl),
        .delta_f     (deltaF),
        .delta_n     (deltaN),
        .event_count (eventCount)
    );

    multi_droop_mgr #(
        .NLVL         (3),
        .HOLD_CYCLES  (0),
        .BRAKE_CYCLES (0)
    ) dut2 (
        .refclk      (refclk),
        .resetn      (resetn),
        .brake       (brake2),
        .brake_lvl   (brakeLvl2),
        .src_mask    (srcMask2),
        .clr_count   (clrCount2),
        .brake_state (brakeState2),
        .active_lvl  (activeLvl2),
        .delta_f     (deltaF2),
        .delta_n     (deltaN2),
        .event_count (eventCount2)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic [3:0] b, input logic [3:0] l, input logic [3:0] m, input logic c);
        @(negedge refclk);
        brake    = b;
        brakeLvl = l;
        srcMask  = m;
        clrCount = c;
        #1;
    endtask

    task automatic applyStimulus2(input logic [3:0] b, input logic [7:0] l, input logic c);
        @(negedge refclk);
        brake2    = b;
        brakeLvl2 = l;
        srcMask2  = 4'hF;
        clrCount2 = c;
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int fBad;
        int rec;
        int first;
        int bad;
        logic [31:0] prev;

        resetn = 1'b0; brake = 4'hF; brakeLvl = 4'h0; srcMask = 4'hF; clrCount = 1'b0;
        brake2 = 4'h0; brakeLvl2 = 8'h0; srcMask2 = 4'hF; clrCount2 = 1'b0;
        #12;
        checkOutput("reset delta_f", deltaF, 0);
        checkOutput("reset delta_n", deltaN, 0);
        checkOutput("reset state", brakeState, 0);
        checkOutput("reset count", eventCount, 0);

        @(negedge refclk);
        resetn = 1'b1;
        brake  = 4'h0;
        #1;

        // Single-cycle request at level 0, full brake / recovery timeline
        applyStimulus(4'b0001, 4'h0, 4'hF, 1'b0);
        checkOutput("kick delta_f", deltaF, 1000000);
        checkOutput("kick delta_n", deltaN, 10);
        checkOutput("kick state", brakeState, 0);
        applyStimulus(4'b0000, 4'h0, 4'hF, 1'b0);
        checkOutput("braking state", brakeState, 1);
        checkOutput("braking count", eventCount, 1);
        checkOutput("braking delta_n", deltaN, 10);
        n = 0; fBad = 0;
        while (brakeState == 2'd1 && n < 600) begin
            n++;
            if (deltaF != 0) fBad++;
            applyStimulus(4'b0000, 4'h0, 4'hF, 1'b0);
        end
        checkOutput("braking length", n, 501);
        checkOutput("braking delta_f zero", fBad, 0);
        rec = 0; first = 0; bad = 0; prev = deltaN;
        checkOutput("recover start delta_n", deltaN, 10);
        while (brakeState == 2'd2 && rec < 500) begin
            rec++;
            if (deltaN == 10) first++;
            if (deltaN != prev && deltaN + 1 != prev) bad++;
            prev = deltaN;
            applyStimulus(4'b0000, 4'h0, 4'hF, 1'b0);
        end
        checkOutput("recover length", rec, 363);
        checkOutput("recover step spacing", first, 33);
        checkOutput("recover monotonic", bad, 0);
        checkOutput("recover last delta_n", prev, 0);
        checkOutput("off state", brakeState, 0);
        checkOutput("off delta_n", deltaN, 0);
        checkOutput("off count", eventCount, 1);

        // Re-brake at delta_n = 6
        applyStimulus(4'b0001, 4'h0, 4'hF, 1'b0);
        applyStimulus(4'b0000, 4'h0, 4'hF, 1'b0);
        n = 0;
        while (!(brakeState == 2'd2 && deltaN == 6) && n < 2000) begin
            n++;
            applyStimulus(4'b0000, 4'h0, 4'hF, 1'b0);
        end
        checkOutput("reach delta_n 6", deltaN, 6);
        applyStimulus(4'b0001, 4'h0, 4'hF, 1'b0);
        checkOutput("rebrake delta_f", deltaF, 0);
        applyStimulus(4'b0001, 4'h0, 4'hF, 1'b0);
        checkOutput("rebrake state", brakeState, 1);
        checkOutput("rebrake delta_n", deltaN, 10);
        checkOutput("rebrake count", eventCount, 3);

        // Escalation while braking: src1 joins at level 1
        applyStimulus(4'b0011, 4'b0010, 4'hF, 1'b0);
        checkOutput("esc delta_f", deltaF, 1000000);
        applyStimulus(4'b0011, 4'b0010, 4'hF, 1'b0);
        checkOutput("esc after delta_f", deltaF, 0);
        checkOutput("esc delta_n", deltaN, 20);
        checkOutput("esc active_lvl", activeLvl, 1);
        checkOutput("esc count", eventCount, 3);
        applyStimulus(4'b0000, 4'h0, 4'hF, 1'b0);
        n = 0;
        while (brakeState == 2'd1 && n < 600) begin
            n++;
            applyStimulus(4'b0000, 4'h0, 4'hF, 1'b0);
        end
        checkOutput("countdown restart length", n, 501);

        // Re-brake below the latched level keeps the latched level
        applyStimulus(4'b0001, 4'h0, 4'hF, 1'b0);
        checkOutput("low rebrake delta_f", deltaF, 0);
        applyStimulus(4'b0000, 4'h0, 4'hF, 1'b0);
        checkOutput("low rebrake delta_n", deltaN, 20);
        checkOutput("low rebrake active_lvl", activeLvl, 1);
        checkOutput("low rebrake count", eventCount, 4);

        // Asynchronous reset in the middle of recovery
        n = 0;
        while (brakeState != 2'd2 && n < 600) begin
            n++;
            applyStimulus(4'b0000, 4'h0, 4'hF, 1'b0);
        end
        checkOutput("reach recovering", brakeState, 2);
        #3;
        resetn = 1'b0;
        brake  = 4'hF;
        #1;
        checkOutput("async reset state", brakeState, 0);
        checkOutput("async reset delta_f", deltaF, 0);
        checkOutput("async reset delta_n", deltaN, 0);
        checkOutput("async reset active_lvl", activeLvl, 0);
        checkOutput("async reset count", eventCount, 0);
        @(negedge refclk);
        resetn = 1'b1;
        brake  = 4'h0;
        #1;
        checkOutput("post reset state", brakeState, 0);
        applyStimulus(4'b0001, 4'h0, 4'hF, 1'b0);
        checkOutput("post reset delta_n", deltaN, 10);
        applyStimulus(4'b0000, 4'h0, 4'hF, 1'b0);
        checkOutput("post reset count", eventCount, 1);

        // Masked source produces no response
        @(negedge refclk);
        resetn = 1'b0;
        @(negedge refclk);
        resetn = 1'b1;
        applyStimulus(4'b0100, 4'h0, 4'b1011, 1'b0);
        checkOutput("mask delta_f", deltaF, 0);
        checkOutput("mask delta_n", deltaN, 0);
        applyStimulus(4'b0100, 4'h0, 4'b1011, 1'b0);
        applyStimulus(4'b0100, 4'h0, 4'b1011, 1'b0);
        checkOutput("mask state", brakeState, 0);
        checkOutput("mask count", eventCount, 0);
        checkOutput("mask delta_n late", deltaN, 0);

        // Level clamp on the NLVL=3 instance: src0 requests level 3, clamped to 2
        applyStimulus2(4'b0011, 8'b0000_0111, 1'b0);
        checkOutput("clamp delta_f", deltaF2, 3000000);
        checkOutput("clamp delta_n", deltaN2, 30);
        applyStimulus2(4'b0000, 8'h00, 1'b0);
        checkOutput("clamp state", brakeState2, 1);
        checkOutput("clamp active_lvl", activeLvl2, 2);
        checkOutput("clamp count", eventCount2, 1);

        // Counter preloaded near the top, then driven by real events
        force dut2.eventCount_q = 16'hFFFC;
        #1;
        release dut2.eventCount_q;
        applyStimulus2(4'b0000, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus2(4'b0011, 8'b0000_0111, 1'b0);
            applyStimulus2(4'b0000, 8'h00, 1'b0);
            checkOutput("saturate count", eventCount2, (k < 3) ? 64'(16'hFFFD + k) : 64'hFFFF);
        end
        applyStimulus2(4'b0011, 8'b0000_0111, 1'b1);
        checkOutput("clear pre count", eventCount2, 16'hFFFF);
        checkOutput("clear pre state", brakeState2, 2);
        applyStimulus2(4'b0000, 8'h00, 1'b0);
        checkOutput("clear wins count", eventCount2, 0);
        checkOutput("clear event state", brakeState2, 1);
        applyStimulus2(4'b0011, 8'b0000_0111, 1'b0);
        applyStimulus2(4'b0000, 8'h00, 1'b0);
        checkOutput("count after clear", eventCount2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
